// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, producing
// sum = a + b + cin (mod 2^WIDTH) and the carry out of the top bit.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             bit_s, bit_c, last_step;

  assign bit_s     = ra_q[0] ^ rb_q[0] ^ carry_q;
  assign bit_c     = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; the final step's sum bit and carry go straight into
  // the result registers so sum/cout only move on the edge that raises done.
  always_comb begin
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        ra_d    = {1'b0, ra_q[WIDTH-1:1]};
        rb_d    = {1'b0, rb_q[WIDTH-1:1]};
        acc_d   = {bit_s, acc_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          sum_d  = acc_d;
          cout_d = bit_c;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver pushes a+b+cin for every
// accepted start, a negedge monitor pops on done and checks hold/reset state.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] hold = '0;
  int         busy_run = 0;
  logic       rst_seen;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_seen <= rst;

  function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Monitor: reset state, busy length, results in order, and output hold.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res",  64'({cout, sum}), 64'd0);
      hold     = '0;
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("busy_len", 64'(busy_run), 64'(W));
        busy_run = 0;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got %0h want none at %0t", {cout, sum}, $time);
        end else begin
          chk("result", 64'({cout, sum}), 64'(exp_q.pop_front()));
        end
        hold = {cout, sum};
      end else begin
        chk("hold", 64'({cout, sum}), 64'(hold));
      end
    end
  end

  // One operation; glitch>0 pulses start with new operands in that SHIFT cycle.
  task automatic op(input logic [W-1:0] x, y, input logic c, input int glitch);
    logic got;
    @(posedge clk); #1;
    a = x; b = y; cin = c; start = 1'b1;
    exp_q.push_back(model(x, y, c));
    got = 1'b0;
    for (int i = 0; i < W + 6 && !got; i++) begin
      @(posedge clk); #1;
      start = (glitch != 0 && i == glitch);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (start) a = 8'h7F;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done want done for %0h+%0h+%0h", x, y, c);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] x, y, d;
    logic         bi;
    logic [2:0]   row;

    // Reset for two edges, then idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    op(8'h05, 8'h03, 1'b0, 0);
    op(8'hFF, 8'h01, 1'b0, 0);
    op(8'hFF, 8'hFF, 1'b1, 0);

    // Full-subtractor rows: D = x^y^bin rebuilt with the subtrahend and borrow-in.
    for (int r = 0; r < 8; r++) begin
      row = 3'(r);
      d   = W'(row[2] ^ row[1] ^ row[0]);
      y   = W'(row[1]);
      bi  = row[0];
      op(d, y, bi, 0);
    end
    op(8'h01, 8'h01, 1'b0, 0);
    op(8'h03, 8'hFE, 1'b1, 0);

    // Start while busy is ignored.
    op(8'h10, 8'h20, 1'b0, 3);

    for (int i = 0; i < 12; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      op(x, y, 1'($urandom), 0);
    end

    // Mid-op reset: no done, result cleared.
    @(posedge clk); #1;
    a = 8'h44; b = 8'h55; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (W + 4) @(posedge clk);

    // Reset and start together: reset wins.
    #1 rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(posedge clk);

    // Start held high: relaunch every W+2 cycles with operands at each capture edge.
    #1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
    exp_q.push_back(model(a, b, cin));
    for (int j = 1; j < 3 * (W + 2); j++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (j % (W + 2) == 0) exp_q.push_back(model(a, b, cin));
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (W + 6) @(posedge clk);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
